// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of four requesters a tenure of up to
// `burst` words into a downstream FIFO, with a registered write port.
module fifo_wr_arbiter #(
  parameter int width = 8,
  parameter int depth = 16,
  parameter int nreq  = 4,
  parameter int burst = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [nreq-1:0]       req,
  input  logic [nreq*width-1:0] din,
  output logic [nreq-1:0]       gnt,
  input  logic                  fifo_full,
  input  logic [4:0]            fifo_count,
  output logic                  fifo_write_en,
  output logic [width-1:0]      fifo_wdata,
  output logic                  busy,
  output logic [1:0]            owner_id
);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [1:0]       owner_nxt;
  logic [3:0]       beat_cnt, beat_nxt;
  logic [1:0]       sel;
  logic             sel_valid;
  logic             stall;
  logic             xfer;
  logic [width-1:0] owner_word;

  // The write strobe is registered, so a word already headed into the last
  // free slot must count as full for the current grant.
  assign stall      = fifo_full | (fifo_write_en & (fifo_count == 5'(depth - 1)));
  assign xfer       = (state == OWN) & ~stall & req[owner_id];
  assign owner_word = din[owner_id*width +: width];
  assign busy       = (state == OWN);

  always_comb begin
    gnt = '0;
    if (state == OWN && !stall) gnt[owner_id] = 1'b1;
  end

  // Search starts just after the previous owner.
  always_comb begin
    logic [1:0] cand;
    sel       = last;
    sel_valid = 1'b0;
    cand      = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!sel_valid && req[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_id;
    last_nxt  = last;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nxt = OWN;
          owner_nxt = sel;
          beat_nxt  = 4'd0;
        end
      end
      OWN: begin
        if (!req[owner_id]) begin
          state_nxt = IDLE;
          last_nxt  = owner_id;
        end else if (xfer) begin
          beat_nxt = beat_cnt + 4'd1;
          if (beat_cnt + 4'd1 == 4'(burst)) begin
            state_nxt = IDLE;
            last_nxt  = owner_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner_id      <= 2'd0;
      last          <= 2'(nreq - 1);
      beat_cnt      <= 4'd0;
      fifo_write_en <= 1'b0;
      fifo_wdata    <= '0;
    end else begin
      state         <= state_nxt;
      owner_id      <= owner_nxt;
      last          <= last_nxt;
      beat_cnt      <= beat_nxt;
      fifo_write_en <= xfer;
      if (xfer) fifo_wdata <= owner_word;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle table for the stall corner
// plus directed scenarios scored against a queue of expected write words.
module tb_fifo_wr_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic           fifo_full;
  logic [4:0]     fifo_count;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_wdata;
  logic           busy;
  logic [1:0]     owner_id;

  fifo_wr_arbiter #(.width(W), .depth(16), .nreq(N), .burst(4)) dut (
    .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .fifo_write_en(fifo_write_en), .fifo_wdata(fifo_wdata),
    .busy(busy), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [4:0] count;
    logic [3:0] gnt;
    logic       busy;
    logic [1:0] owner;
    logic       we;
  } vec_t;

  vec_t         vecs[10];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] words[N][8];
  int           cnt[N];
  int           idx[N];
  logic [W-1:0] sb[$];
  logic [1:0]   owners[$];
  int           write_cycles[$];
  int           cyc = 0;
  logic         prev_busy = 1'b0;
  logic         use_model = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (idx[i] < cnt[i]);
    return r;
  endfunction

  function automatic logic [N*W-1:0] model_din();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++)
      if (idx[i] < cnt[i]) d[i*W +: W] = words[i][idx[i]];
    return d;
  endfunction

  task automatic drive();
    if (use_model) req = model_req();
    din = model_din();
  endtask

  task automatic load(input int r, input logic [W-1:0] base, input int n);
    cnt[r] = n;
    idx[r] = 0;
    for (int k = 0; k < n; k++) words[r][k] = base + W'(k);
  endtask

  task automatic push_range(input int r, input int from, input int to);
    for (int k = from; k <= to; k++) sb.push_back(words[r][k]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      idx[i] = 0;
    end
  endtask

  // Every write the DUT issues must match the next expected word.
  task automatic checkOutput();
    logic [W-1:0] exp;
    write_cycles.push_back(cyc);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_write actual=%0h expected=none", fifo_wdata);
    end else begin
      exp = sb.pop_front();
      check("wdata", 32'(fifo_wdata), 32'(exp));
    end
  endtask

  // Note which requester words are consumed, cross the edge, then score.
  task automatic endCycle();
    logic [N-1:0] taken;
    taken = gnt & req;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (taken[i]) idx[i]++;
    if (busy && !prev_busy) owners.push_back(owner_id);
    prev_busy = busy;
    if (fifo_write_en) checkOutput();
    drive();
  endtask

  task automatic applyStimulus();
    drive();
    #1;
    endCycle();
  endtask

  task automatic run_scenario(input string name, input int maxc);
    int n;
    n = 0;
    while ((model_req() != '0 || busy) && n < maxc) begin
      applyStimulus();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=%0d expected<%0d cycles", name, n, maxc);
    end
    repeat (2) applyStimulus();
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_owners(input string name, input int n, input logic [7:0] seq);
    check({name, "_owner_count"}, 32'(owners.size()), 32'(n));
    for (int k = 0; k < n && k < owners.size(); k++)
      check({name, "_owner"}, 32'(owners[k]), 32'(seq[(3-k)*2 +: 2]));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b0001, 1'b0, 5'd0,  4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{4'b0001, 1'b0, 5'd14, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[2] = '{4'b0001, 1'b0, 5'd15, 4'b0000, 1'b1, 2'd0, 1'b1};
    vecs[3] = '{4'b0001, 1'b1, 5'd16, 4'b0000, 1'b1, 2'd0, 1'b0};
    vecs[4] = '{4'b0001, 1'b0, 5'd14, 4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[5] = '{4'b0001, 1'b0, 5'd14, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[6] = '{4'b0001, 1'b0, 5'd14, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[7] = '{4'b0001, 1'b0, 5'd0,  4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[8] = '{4'b0000, 1'b0, 5'd0,  4'b0001, 1'b1, 2'd0, 1'b0};
    vecs[9] = '{4'b0000, 1'b0, 5'd0,  4'b0000, 1'b0, 2'd0, 1'b0};

    reset = 1'b0;
    req = '0;
    din = '0;
    fifo_full = 1'b0;
    fifo_count = '0;
    clear_model();
    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(fifo_write_en), 32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_owner", 32'(owner_id), 32'd0);

    // Stall table: requester 0 alone, FIFO near full.
    load(0, 8'h10, 4);
    push_range(0, 0, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int v = 0; v < 10; v++) begin
      req = vecs[v].req;
      fifo_full = vecs[v].full;
      fifo_count = vecs[v].count;
      drive();
      #1;
      check($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("tbl%0d_owner", v), 32'(owner_id), 32'(vecs[v].owner));
      check($sformatf("tbl%0d_we", v), 32'(fifo_write_en), 32'(vecs[v].we));
      endCycle();
    end
    check("tbl_sb_empty", 32'(sb.size()), 32'd0);
    fifo_full = 1'b0;
    fifo_count = '0;

    // Reset held with every requester active, then release.
    clear_model();
    use_model = 1'b1;
    for (int i = 0; i < N; i++) load(i, 8'h20 + 8'(i * 16), 4);
    for (int i = 0; i < N; i++) push_range(i, 0, 3);
    drive();
    reset = 1'b0;
    #1;
    check("rst2_gnt", 32'(gnt), 32'd0);
    check("rst2_wdata", 32'(fifo_wdata), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    prev_busy = 1'b0;
    owners.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus();
    check("rel_busy", 32'(busy), 32'd1);
    check("rel_owner", 32'(owner_id), 32'd0);
    run_scenario("reset_all", 60);
    check_owners("reset_all", 4, 8'b00_01_10_11);

    // Round robin between 0 and 2, two tenures each.
    clear_model();
    owners.delete();
    write_cycles.delete();
    load(0, 8'h60, 8);
    load(2, 8'h70, 8);
    push_range(0, 0, 3);
    push_range(2, 0, 3);
    push_range(0, 4, 7);
    push_range(2, 4, 7);
    run_scenario("rr", 60);
    check_owners("rr", 4, 8'b00_10_00_10);
    check("rr_writes", 32'(write_cycles.size()), 32'd16);
    if (write_cycles.size() == 16) begin
      check("rr_span", 32'(write_cycles[15] - write_cycles[0]), 32'd18);
      check("rr_gap", 32'(write_cycles[4] - write_cycles[3]), 32'd2);
      check("rr_run", 32'(write_cycles[3] - write_cycles[0]), 32'd3);
    end

    // Requester 3 drops out after two words.
    clear_model();
    owners.delete();
    write_cycles.delete();
    load(3, 8'h80, 2);
    push_range(3, 0, 1);
    run_scenario("early", 30);
    check_owners("early", 1, 8'b11_00_00_00);
    check("early_writes", 32'(write_cycles.size()), 32'd2);
    check("early_idle", 32'(busy), 32'd0);

    // Two requesters with distinct data; order shows priority after 3.
    clear_model();
    owners.delete();
    load(1, 8'hA1, 4);
    load(2, 8'hB1, 4);
    push_range(1, 0, 3);
    push_range(2, 0, 3);
    run_scenario("data", 40);
    check_owners("data", 2, 8'b01_10_00_00);

    // Reset in the middle of a tenure from requester 2.
    clear_model();
    write_cycles.delete();
    load(2, 8'hC0, 4);
    push_range(2, 0, 1);
    for (int n = 0; n < 20 && write_cycles.size() < 2; n++) applyStimulus();
    check("mid_two_writes", 32'(write_cycles.size()), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_we", 32'(fifo_write_en), 32'd0);
    check("mid_gnt", 32'(gnt), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    clear_model();
    load(0, 8'hD0, 4);
    load(2, 8'hE0, 4);
    push_range(0, 0, 3);
    push_range(2, 0, 3);
    repeat (2) applyStimulus();
    reset = 1'b1;
    prev_busy = 1'b0;
    owners.delete();
    run_scenario("post_rst", 40);
    check_owners("post_rst", 2, 8'b00_10_00_00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
